mem_rd_arbiter: RTL and testbench
=================================

# mem_rd_arbiter

Two-requester read arbiter that shares one AXI read port (AR/R) between the instruction cache and the data cache of the custom CPU. Accepts one read request at a time, drives a single AXI burst on the shared port, and steers the returning beats back to the granted requester until `rlast`. Sits between the two cache tops and the `cpu_mem_*` AXI master port of the custom CPU wrapper.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, requester address width; AXI address is zero-extended to 40 bits.
- `DATA_WIDTH`, 32, read data width.

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high.
  - `cpu_clk`  in  1  clock.
  - `cpu_reset`  in  1  synchronous, active-high reset.
- Instruction-cache side:
  - `inst_rd_req_valid`, `inst_rd_req_addr`, `inst_rd_req_len`  in  1/ADDR_WIDTH/8  request valid, address, AXI arlen.
  - `inst_rd_req_ready`  out  1  request accepted.
  - `inst_rd_rsp_valid`, `inst_rd_rsp_data`, `inst_rd_rsp_last`  out  1/DATA_WIDTH/1  response beat.
  - `inst_rd_rsp_ready`  in  1  beat accepted.
- Data-cache side: `data_rd_req_*` and `data_rd_rsp_*`, identical to the instruction-cache side.
- Shared AXI port:
  - `mem_araddr`  out  40  zero-extended latched address.
  - `mem_arvalid`  out  1.
  - `mem_arready`  in  1.
  - `mem_arlen`  out  8.
  - `mem_arsize`  out  3  constant 3'b010.
  - `mem_arburst`  out  2  constant 2'b01 (INCR).
  - `mem_rdata`  in  DATA_WIDTH.
  - `mem_rvalid`  in  1.
  - `mem_rlast`  in  1.
  - `mem_rready`  out  1.

## Operation
State machine: `IDLE`, `AR_INST`, `AR_DATA`, `R_INST`, `R_DATA`.

- **IDLE:**
  - If any `*_rd_req_valid` is high, choose the winner.
  - Assert the winner's `*_rd_req_ready` combinationally in the same cycle.
  - Latch the winner's addr/len.
  - Go to `AR_x`. The loser's ready stays 0.
- **AR_x:**
  - `mem_arvalid`=1 with the latched addr/len.
  - Addr/len stay stable until `mem_arready`, then go to `R_x`.
- **R_x:**
  - `*_rd_rsp_valid/data/last` of the granted side = `mem_rvalid/rdata/rlast`.
  - `mem_rready` = granted side's `*_rd_rsp_ready`.
  - On `mem_rvalid & mem_rready & mem_rlast`, go to `IDLE`.
- **Ungranted side:** `*_rd_rsp_valid`=0 always.
- **Outside `R_x`:** `mem_rready`=0, and `mem_rvalid` is ignored.
- **Burst length:** not counted. `rlast` alone terminates the grant.
- **Request ownership:** a requester dropping valid after acceptance has no effect; the request is owned by the arbiter.

## Timing
- Reset values: state `IDLE`; all `*_req_ready`, `*_rsp_valid`, `mem_arvalid`, `mem_rready` = 0; `mem_araddr`=0, `mem_arlen`=0; round-robin pointer = "inst last served".
- Request acceptance to `mem_arvalid` high: 1 cycle (registered).
- `mem_arready` already high: AR handshake completes in that first `AR_x` cycle, and `R_x` is entered next cycle.
- Response path is combinational. Zero added latency per beat, full throughput when the requester's ready is held high.
- Last beat handshake to the next grant: the next request can be accepted 1 cycle later (in `IDLE`). Minimum turnaround is 1 idle cycle.
- Simultaneous requests in `IDLE` resolve per Configuration.
- Requests arriving in non-`IDLE` states wait; ready stays low.
- Reset mid-operation (any state) returns to `IDLE` next edge with reset values. The memory side is reset on the same `cpu_reset`, so no stale beats are expected.

## Configuration
- `MEM_RD_ARB_RR_EN` defined: round-robin. On a tie, grant the side not served last. The pointer updates on each acceptance.
- Not defined: fixed priority, data cache over instruction cache. The pointer register is not built.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding constants (`ARB_IDLE`, `ARB_AR_INST`, …);
  - grant IDs `GNT_INST`=0, `GNT_DATA`=1;
  - `AXI_SIZE_4B`, `AXI_BURST_INCR`.
- One natural sub-module: `rr_arb2`. It is a two-input grant picker with a last-served pointer and a macro-selected fixed-priority mode. It is instantiated once for the `IDLE` decision.

## Test plan
- **Single inst request:** inst req addr 0x1000, len 7; arready delayed 3 cycles.
  - Required: `mem_arvalid` high from cycle+1, `mem_araddr`=0x00_0000_1000, held until arready.
  - Required: 8 beats forwarded to the inst side, `data_rsp_valid`=0 throughout, back to `IDLE` after `rlast`.
- **Simultaneous requests (`MEM_RD_ARB_RR_EN` on):** both sides request at reset exit.
  - Required: data served first, then inst, then data; grants alternate with no starvation.
- **Simultaneous requests, macro off:** both sides request continuously.
  - Required: data always granted; inst granted only when data valid is low in `IDLE`.
- **Backpressure:** inst `rsp_ready` toggles 1-0-1 during an 8-beat burst.
  - Required: `mem_rready` mirrors it; every beat is delivered exactly once, in order.
- **Stray beat:** `mem_rvalid` pulsed while in `IDLE`.
  - Required: `mem_rready`=0 and no `*_rsp_valid`.
- **Reset mid-burst:** `cpu_reset` asserted at beat 4 of a data burst.
  - Required: next cycle all outputs at reset values and state `IDLE`; a new inst request is accepted normally afterward.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache read-port arbiter.
package mem_arb_pkg;

    localparam int unsigned AXI_ADDR_WIDTH = 40;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_AR_INST,
        ARB_AR_DATA,
        ARB_R_INST,
        ARB_R_DATA
    } arb_state_e;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Bundle of the two cache read ports and the shared AXI read port.
// master: the arbiter's view; slave: the caches and memory together.
interface mem_rd_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                      inst_rd_req_valid;
    logic [ADDR_WIDTH-1:0]     inst_rd_req_addr;
    logic [7:0]                inst_rd_req_len;
    logic                      inst_rd_req_ready;
    logic                      inst_rd_rsp_valid;
    logic [DATA_WIDTH-1:0]     inst_rd_rsp_data;
    logic                      inst_rd_rsp_last;
    logic                      inst_rd_rsp_ready;

    logic                      data_rd_req_valid;
    logic [ADDR_WIDTH-1:0]     data_rd_req_addr;
    logic [7:0]                data_rd_req_len;
    logic                      data_rd_req_ready;
    logic                      data_rd_rsp_valid;
    logic [DATA_WIDTH-1:0]     data_rd_rsp_data;
    logic                      data_rd_rsp_last;
    logic                      data_rd_rsp_ready;

    logic [AXI_ADDR_WIDTH-1:0] mem_araddr;
    logic                      mem_arvalid;
    logic                      mem_arready;
    logic [7:0]                mem_arlen;
    logic [2:0]                mem_arsize;
    logic [1:0]                mem_arburst;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      mem_rvalid;
    logic                      mem_rlast;
    logic                      mem_rready;

    modport master (
        input  inst_rd_req_valid, inst_rd_req_addr, inst_rd_req_len, inst_rd_rsp_ready,
        output inst_rd_req_ready, inst_rd_rsp_valid, inst_rd_rsp_data, inst_rd_rsp_last,
        input  data_rd_req_valid, data_rd_req_addr, data_rd_req_len, data_rd_rsp_ready,
        output data_rd_req_ready, data_rd_rsp_valid, data_rd_rsp_data, data_rd_rsp_last,
        output mem_araddr, mem_arvalid, mem_arlen, mem_arsize, mem_arburst, mem_rready,
        input  mem_arready, mem_rdata, mem_rvalid, mem_rlast
    );

    modport slave (
        output inst_rd_req_valid, inst_rd_req_addr, inst_rd_req_len, inst_rd_rsp_ready,
        input  inst_rd_req_ready, inst_rd_rsp_valid, inst_rd_rsp_data, inst_rd_rsp_last,
        output data_rd_req_valid, data_rd_req_addr, data_rd_req_len, data_rd_rsp_ready,
        input  data_rd_req_ready, data_rd_rsp_valid, data_rd_rsp_data, data_rd_rsp_last,
        input  mem_araddr, mem_arvalid, mem_arlen, mem_arsize, mem_arburst, mem_rready,
        output mem_arready, mem_rdata, mem_rvalid, mem_rlast
    );

endinterface

// File: rtl/mem_rd_arbiter_rr_arb2.sv
// Two-input grant picker. MEM_RD_ARB_RR_EN selects round-robin with a
// last-served pointer; otherwise data has fixed priority over inst and
// the pointer (and its clock/reset/update ports) does not exist.
module rr_arb2
    import mem_arb_pkg::*;
(
`ifdef MEM_RD_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic accept,
`endif
    input  logic req_inst,
    input  logic req_data,
    output logic gnt_valid,
    output logic gnt_id
);

`ifdef MEM_RD_ARB_RR_EN
    logic last_q;

    // Remember which side won the most recent accepted grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= GNT_INST;
        end else if (accept && gnt_valid) begin
            last_q <= gnt_id;
        end
    end

    // On a tie, favour the side that was not served last.
    always_comb begin
        gnt_valid = req_inst | req_data;
        gnt_id    = req_data ? GNT_DATA : GNT_INST;
        if (req_inst && req_data) begin
            gnt_id = (last_q == GNT_INST) ? GNT_DATA : GNT_INST;
        end
    end
`else
    // Data cache always wins a tie.
    always_comb begin
        gnt_valid = req_inst | req_data;
        gnt_id    = req_data ? GNT_DATA : GNT_INST;
    end
`endif

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one AXI read port between the instruction and data caches.
// One burst in flight; beats are steered to the grantee until rlast.
// Optional macro: MEM_RD_ARB_RR_EN (round-robin tie-break).
module mem_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
)(
    input  logic                  cpu_clk,
    input  logic                  cpu_reset,
    mem_rd_arbiter_if.master      arb_bus
);

    arb_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    gnt_valid;
    logic                    gnt_id;
    logic                    in_idle;

    assign in_idle = (state_q == ARB_IDLE);
    assign rdata   = arb_bus.mem_rdata;

    rr_arb2 u_rr_arb2 (
`ifdef MEM_RD_ARB_RR_EN
        .clk       (cpu_clk),
        .rst       (cpu_reset),
        .accept    (in_idle),
`endif
        .req_inst  (arb_bus.inst_rd_req_valid),
        .req_data  (arb_bus.data_rd_req_valid),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign arb_bus.mem_araddr  = AXI_ADDR_WIDTH'(addr_q);
    assign arb_bus.mem_arlen   = len_q;
    assign arb_bus.mem_arsize  = AXI_SIZE_4B;
    assign arb_bus.mem_arburst = AXI_BURST_INCR;

    // State register plus the request latched at acceptance.
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state_q <= ARB_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            if (in_idle && gnt_valid) begin
                addr_q <= (gnt_id == GNT_DATA) ? arb_bus.data_rd_req_addr : arb_bus.inst_rd_req_addr;
                len_q  <= (gnt_id == GNT_DATA) ? arb_bus.data_rd_req_len  : arb_bus.inst_rd_req_len;
            end
        end
    end

    // Next state, handshakes and response steering.
    always_comb begin
        state_d                   = state_q;
        arb_bus.inst_rd_req_ready = 1'b0;
        arb_bus.data_rd_req_ready = 1'b0;
        arb_bus.inst_rd_rsp_valid = 1'b0;
        arb_bus.inst_rd_rsp_data  = '0;
        arb_bus.inst_rd_rsp_last  = 1'b0;
        arb_bus.data_rd_rsp_valid = 1'b0;
        arb_bus.data_rd_rsp_data  = '0;
        arb_bus.data_rd_rsp_last  = 1'b0;
        arb_bus.mem_arvalid       = 1'b0;
        arb_bus.mem_rready        = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    if (gnt_id == GNT_DATA) begin
                        arb_bus.data_rd_req_ready = 1'b1;
                        state_d                   = ARB_AR_DATA;
                    end else begin
                        arb_bus.inst_rd_req_ready = 1'b1;
                        state_d                   = ARB_AR_INST;
                    end
                end
            end
            ARB_AR_INST: begin
                arb_bus.mem_arvalid = 1'b1;
                if (arb_bus.mem_arready) state_d = ARB_R_INST;
            end
            ARB_AR_DATA: begin
                arb_bus.mem_arvalid = 1'b1;
                if (arb_bus.mem_arready) state_d = ARB_R_DATA;
            end
            ARB_R_INST: begin
                arb_bus.inst_rd_rsp_valid = arb_bus.mem_rvalid;
                arb_bus.inst_rd_rsp_data  = rdata;
                arb_bus.inst_rd_rsp_last  = arb_bus.mem_rlast;
                arb_bus.mem_rready        = arb_bus.inst_rd_rsp_ready;
                if (arb_bus.mem_rvalid && arb_bus.inst_rd_rsp_ready && arb_bus.mem_rlast)
                    state_d = ARB_IDLE;
            end
            ARB_R_DATA: begin
                arb_bus.data_rd_rsp_valid = arb_bus.mem_rvalid;
                arb_bus.data_rd_rsp_data  = rdata;
                arb_bus.data_rd_rsp_last  = arb_bus.mem_rlast;
                arb_bus.mem_rready        = arb_bus.data_rd_rsp_ready;
                if (arb_bus.mem_rvalid && arb_bus.data_rd_rsp_ready && arb_bus.mem_rlast)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter; honours MEM_RD_ARB_RR_EN if defined.
module tb_mem_rd_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   total    = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;

    always #5 clk = ~clk;

    mem_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .cpu_clk   (clk),
        .cpu_reset (rst),
        .arb_bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.inst_rd_req_valid = 0; bus.inst_rd_req_addr = '0; bus.inst_rd_req_len = '0;
        bus.inst_rd_rsp_ready = 0;
        bus.data_rd_req_valid = 0; bus.data_rd_req_addr = '0; bus.data_rd_req_len = '0;
        bus.data_rd_rsp_ready = 0;
        bus.mem_arready = 0; bus.mem_rdata = '0; bus.mem_rvalid = 0; bus.mem_rlast = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // Called just after a negedge with request valids already driven.
    task automatic accept(input bit side, input logic [39:0] exp_addr, input logic [7:0] exp_len,
                          input int ar_delay, input bit keep_valid, input string tag);
        #1;
        chk({tag, ".win_ready"},  side ? bus.data_rd_req_ready : bus.inst_rd_req_ready, 1);
        chk({tag, ".lose_ready"}, side ? bus.inst_rd_req_ready : bus.data_rd_req_ready, 0);
        chk({tag, ".arvalid_idle"}, bus.mem_arvalid, 0);
        @(negedge clk);
        if (!keep_valid) begin
            if (side) bus.data_rd_req_valid = 0;
            else      bus.inst_rd_req_valid = 0;
        end
        for (int i = 0; i <= ar_delay; i++) begin
            bus.mem_arready = (i == ar_delay);
            #1;
            chk({tag, ".arvalid"}, bus.mem_arvalid, 1);
            chk({tag, ".araddr"},  bus.mem_araddr, exp_addr);
            chk({tag, ".arlen"},   bus.mem_arlen, exp_len);
            chk({tag, ".ready_ar"}, {bus.inst_rd_req_ready, bus.data_rd_req_ready}, 0);
            @(negedge clk);
        end
        bus.mem_arready = 0;
        #1;
        chk({tag, ".arvalid_r"}, bus.mem_arvalid, 0);
    endtask

    task automatic burst(input bit side, input int n, input logic [31:0] base, input string tag);
        bus.inst_rd_rsp_ready = 1;
        bus.data_rd_rsp_ready = 1;
        for (int i = 0; i < n; i++) begin
            bus.mem_rvalid = 1;
            bus.mem_rdata  = base + 32'(i);
            bus.mem_rlast  = (i == n - 1);
            #1;
            chk({tag, ".rsp_valid"}, side ? bus.data_rd_rsp_valid : bus.inst_rd_rsp_valid, 1);
            chk({tag, ".rsp_data"},  side ? bus.data_rd_rsp_data  : bus.inst_rd_rsp_data, base + 32'(i));
            chk({tag, ".rsp_last"},  side ? bus.data_rd_rsp_last  : bus.inst_rd_rsp_last, (i == n - 1));
            chk({tag, ".other_valid"}, side ? bus.inst_rd_rsp_valid : bus.data_rd_rsp_valid, 0);
            chk({tag, ".rready"}, bus.mem_rready, 1);
            @(negedge clk);
        end
        bus.mem_rvalid = 0;
        bus.mem_rlast  = 0;
    endtask

    initial begin
        int beat;
        int cyc;
        logic r;

        // Reset values
        do_reset();
        #1;
        chk("rst.arvalid", bus.mem_arvalid, 0);
        chk("rst.araddr",  bus.mem_araddr, 0);
        chk("rst.arlen",   bus.mem_arlen, 0);
        chk("rst.arsize",  bus.mem_arsize, 3'b010);
        chk("rst.arburst", bus.mem_arburst, 2'b01);
        chk("rst.rready",  bus.mem_rready, 0);
        chk("rst.req_ready", {bus.inst_rd_req_ready, bus.data_rd_req_ready}, 0);
        chk("rst.rsp_valid", {bus.inst_rd_rsp_valid, bus.data_rd_rsp_valid}, 0);
        @(negedge clk);

        // Single inst request, arready delayed 3 cycles, 8 beats
        bus.inst_rd_req_valid = 1; bus.inst_rd_req_addr = 32'h1000; bus.inst_rd_req_len = 8'd7;
        accept(0, 40'h00_0000_1000, 8'd7, 3, 0, "single");
        burst(0, 8, 32'hA0, "single");

        // Next request accepted immediately in IDLE after rlast
        bus.data_rd_req_valid = 1; bus.data_rd_req_addr = 32'h3000; bus.data_rd_req_len = 8'd1;
        accept(1, 40'h00_0000_3000, 8'd1, 0, 0, "turn");
        burst(1, 2, 32'hC0, "turn");

        // Stray beat in IDLE is ignored
        bus.mem_rvalid = 1; bus.mem_rlast = 1; bus.mem_rdata = 32'hDEAD;
        bus.inst_rd_rsp_ready = 1; bus.data_rd_rsp_ready = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stray.rready", bus.mem_rready, 0);
            chk("stray.rsp_valid", {bus.inst_rd_rsp_valid, bus.data_rd_rsp_valid}, 0);
            @(negedge clk);
        end
        bus.mem_rvalid = 0; bus.mem_rlast = 0;

        // Backpressure: inst rsp_ready toggles 1-0-1-... over an 8-beat burst
        bus.inst_rd_req_valid = 1; bus.inst_rd_req_addr = 32'h1100; bus.inst_rd_req_len = 8'd7;
        accept(0, 40'h00_0000_1100, 8'd7, 0, 0, "bp");
        beat = 0;
        cyc  = 0;
        while (beat < 8 && cyc < 30) begin
            r = (cyc % 2 == 0);
            bus.inst_rd_rsp_ready = r;
            bus.mem_rvalid = 1;
            bus.mem_rdata  = 32'hB0 + 32'(beat);
            bus.mem_rlast  = (beat == 7);
            #1;
            chk("bp.rready", bus.mem_rready, r);
            chk("bp.rsp_valid", bus.inst_rd_rsp_valid, 1);
            chk("bp.rsp_data", bus.inst_rd_rsp_data, 32'hB0 + 32'(beat));
            chk("bp.data_valid", bus.data_rd_rsp_valid, 0);
            if (bus.mem_rready && bus.mem_rvalid) beat++;
            cyc++;
            @(negedge clk);
        end
        bus.mem_rvalid = 0; bus.mem_rlast = 0;
        chk("bp.beats", beat, 8);
        chk("bp.cycles", cyc, 15);
        #1;
        chk("bp.idle_rready", bus.mem_rready, 0);

        // Simultaneous requests from reset exit, both held high
        do_reset();
        bus.inst_rd_req_valid = 1; bus.inst_rd_req_addr = 32'h2000; bus.inst_rd_req_len = 8'd0;
        bus.data_rd_req_valid = 1; bus.data_rd_req_addr = 32'h3000; bus.data_rd_req_len = 8'd0;
`ifdef MEM_RD_ARB_RR_EN
        accept(1, 40'h00_0000_3000, 8'd0, 0, 1, "rr1");
        burst(1, 1, 32'h11, "rr1");
        accept(0, 40'h00_0000_2000, 8'd0, 0, 1, "rr2");
        burst(0, 1, 32'h22, "rr2");
        accept(1, 40'h00_0000_3000, 8'd0, 0, 1, "rr3");
        burst(1, 1, 32'h33, "rr3");
`else
        accept(1, 40'h00_0000_3000, 8'd0, 0, 1, "fix1");
        burst(1, 1, 32'h11, "fix1");
        accept(1, 40'h00_0000_3000, 8'd0, 0, 1, "fix2");
        burst(1, 1, 32'h22, "fix2");
        bus.data_rd_req_valid = 0;
        accept(0, 40'h00_0000_2000, 8'd0, 0, 1, "fix3");
        burst(0, 1, 32'h33, "fix3");
`endif
        bus.inst_rd_req_valid = 0;
        bus.data_rd_req_valid = 0;

        // Reset asserted at beat 4 of a data burst
        bus.data_rd_req_valid = 1; bus.data_rd_req_addr = 32'h4000; bus.data_rd_req_len = 8'd7;
        accept(1, 40'h00_0000_4000, 8'd7, 0, 0, "mid");
        bus.data_rd_rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = 1; bus.mem_rdata = 32'h50 + 32'(i); bus.mem_rlast = 0;
            @(negedge clk);
        end
        bus.mem_rdata = 32'h54;
        rst = 1;
        #1;
        chk("mid.beat4_valid", bus.data_rd_rsp_valid, 1);
        @(negedge clk);
        #1;
        chk("mid.rst_rsp_valid", {bus.inst_rd_rsp_valid, bus.data_rd_rsp_valid}, 0);
        chk("mid.rst_rready",    bus.mem_rready, 0);
        chk("mid.rst_arvalid",   bus.mem_arvalid, 0);
        chk("mid.rst_araddr",    bus.mem_araddr, 0);
        chk("mid.rst_arlen",     bus.mem_arlen, 0);
        chk("mid.rst_req_ready", {bus.inst_rd_req_ready, bus.data_rd_req_ready}, 0);
        @(negedge clk);
        rst = 0;
        clear_inputs();
        bus.inst_rd_req_valid = 1; bus.inst_rd_req_addr = 32'h5000; bus.inst_rd_req_len = 8'd0;
        accept(0, 40'h00_0000_5000, 8'd0, 1, 0, "post");
        burst(0, 1, 32'h77, "post");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
